// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller:
// PC source selects, jump kinds and sequencer states.
package pipe_pkg;

   localparam logic [2:0] PC_SRC_SEQ = 3'b000;
   localparam logic [2:0] PC_SRC_BR  = 3'b001;
   localparam logic [2:0] PC_SRC_J   = 3'b010;
   localparam logic [2:0] PC_SRC_JR  = 3'b011;
   localparam logic [2:0] PC_SRC_IRQ = 3'b100;
   localparam logic [2:0] PC_SRC_EXC = 3'b101;

   localparam logic [1:0] JUMP_NONE = 2'b00;
   localparam logic [1:0] JUMP_J    = 2'b01;
   localparam logic [1:0] JUMP_JR   = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEMWAIT,
      ST_LDUSE
   } state_t;

   function automatic logic lduse_hit(
      input logic       memread,
      input logic [4:0] ex_rt,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      return memread && (ex_rt != 5'd0) &&
             ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and the control
// outputs driven back into the pipeline registers.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);

   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic             ex_branch_taken;
   logic [1:0]       id_jump;
   logic             undef_instr;
   logic             irq_req;
   logic             kernel_mode;
   logic             mem_busy;

   logic             pc_write;
   logic [2:0]       pc_src;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic             epc_save;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   modport master (
      output id_rs, id_rt, id_uses_rt,
      output ex_memread, ex_rt,
      output ex_branch_taken, id_jump,
      output undef_instr, irq_req,
      output kernel_mode, mem_busy,
      input  pc_write, pc_src,
      input  ifid_write, ifid_flush,
      input  idex_flush, epc_save,
      input  stall_cycles, flush_events
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt,
      input  ex_memread, ex_rt,
      input  ex_branch_taken, id_jump,
      input  undef_instr, irq_req,
      input  kernel_mode, mem_busy,
      output pc_write, pc_src,
      output ifid_write, ifid_flush,
      output idex_flush, epc_save,
      output stall_cycles, flush_events
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones,
// never wraps back to zero.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   // count up until all-ones, then hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe:
// one fixed-priority action per cycle.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int LDUSE_BUBBLES = 1,
   parameter int CNT_W         = 16
) (
   input logic         clk,
   input logic         reset,
   pipe_hazard_ctrl_if.slave bus
);

   localparam logic [1:0] BUB_LOAD =
      2'(LDUSE_BUBBLES - 1);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       irq_q, irq_d;
   logic       take_irq;
   logic       hazard;
   logic       bubble;
   logic       jmp_any;

   logic       pc_write;
   logic [2:0] pc_src;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_flush;
   logic       epc_save;

   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   assign hazard = lduse_hit(bus.ex_memread, bus.ex_rt,
                             bus.id_rs, bus.id_rt,
                             bus.id_uses_rt);

   // a bubble is still owed after LDUSE or a freeze inside it
   assign bubble  = (state_q != ST_RUN) && (cnt_q != 2'd0);
   assign jmp_any = bus.id_jump != JUMP_NONE;

   // state, bubble counter and interrupt latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 2'd0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         irq_q   <= irq_d;
      end
   end

   // priority resolver: next state and control outputs
   always_comb begin
      state_d    = ST_RUN;
      cnt_d      = cnt_q;
      take_irq   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_SEQ;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      epc_save   = 1'b0;
      priority case (1'b1)
         bus.mem_busy: begin
            state_d = ST_MEMWAIT;
         end
         bubble: begin
            idex_flush = 1'b1;
            cnt_d      = cnt_q - 2'd1;
            state_d    = (cnt_q == 2'd1) ? ST_RUN : ST_LDUSE;
         end
         bus.undef_instr: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_EXC;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            epc_save   = 1'b1;
         end
         bus.ex_branch_taken: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_BR;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         irq_q: begin
            take_irq   = 1'b1;
            pc_write   = 1'b1;
            pc_src     = PC_SRC_IRQ;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            epc_save   = 1'b1;
         end
         hazard: begin
            idex_flush = 1'b1;
            cnt_d      = BUB_LOAD;
            state_d    = (BUB_LOAD != 2'd0) ? ST_LDUSE : ST_RUN;
         end
         (jmp_any && (bus.id_jump == JUMP_JR)): begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JR;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
         end
         (jmp_any && (bus.id_jump == JUMP_J)): begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_J;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
         end
         default: begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
         end
      endcase
      if (reset) begin
         pc_write   = 1'b0;
         pc_src     = PC_SRC_SEQ;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         epc_save   = 1'b0;
      end
   end

   // a new request re-latches even in the cycle one is taken
   assign irq_d = (bus.irq_req && !bus.kernel_mode) ||
                  (irq_q && !take_irq);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!ifid_write),
      .clear (1'b0),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ifid_flush),
      .clear (1'b0),
      .count (flush_cnt)
   );

   assign bus.pc_write     = pc_write;
   assign bus.pc_src       = pc_src;
   assign bus.ifid_write   = ifid_write;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.idex_flush   = idex_flush;
   assign bus.epc_save     = epc_save;
   assign bus.stall_cycles = stall_cnt;
   assign bus.flush_events = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random bench for pipe_hazard_ctrl with a
// rule-level reference model (1- and 2-bubble variants).
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] rs, rt, ert;
   logic       uses_rt, memrd, brt, undef;
   logic       irq, kmode, busy;
   logic [1:0] jmp;

   pipe_hazard_ctrl_if #(.CNT_W(16)) if0 ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  if1 ();

   assign if0.id_rs = rs;
   assign if0.id_rt = rt;
   assign if0.id_uses_rt = uses_rt;
   assign if0.ex_memread = memrd;
   assign if0.ex_rt = ert;
   assign if0.ex_branch_taken = brt;
   assign if0.id_jump = jmp;
   assign if0.undef_instr = undef;
   assign if0.irq_req = irq;
   assign if0.kernel_mode = kmode;
   assign if0.mem_busy = busy;

   assign if1.id_rs = rs;
   assign if1.id_rt = rt;
   assign if1.id_uses_rt = uses_rt;
   assign if1.ex_memread = memrd;
   assign if1.ex_rt = ert;
   assign if1.ex_branch_taken = brt;
   assign if1.id_jump = jmp;
   assign if1.undef_instr = undef;
   assign if1.irq_req = irq;
   assign if1.kernel_mode = kmode;
   assign if1.mem_busy = busy;

   pipe_hazard_ctrl #(.LDUSE_BUBBLES(1), .CNT_W(16)) dut0 (
      .clk   (clk),
      .reset (rst),
      .bus   (if0)
   );

   pipe_hazard_ctrl #(.LDUSE_BUBBLES(2), .CNT_W(4)) dut1 (
      .clk   (clk),
      .reset (rst),
      .bus   (if1)
   );

   logic [7:0]  ctl [2];
   logic [31:0] so  [2];
   logic [31:0] fo  [2];

   assign ctl[0] = {if0.pc_write, if0.pc_src, if0.ifid_write,
                    if0.ifid_flush, if0.idex_flush, if0.epc_save};
   assign ctl[1] = {if1.pc_write, if1.pc_src, if1.ifid_write,
                    if1.ifid_flush, if1.idex_flush, if1.epc_save};
   assign so[0] = 32'(if0.stall_cycles);
   assign so[1] = 32'(if1.stall_cycles);
   assign fo[0] = 32'(if0.flush_events);
   assign fo[1] = 32'(if1.flush_events);

   // reference model: bubbles still owed, irq latch, counter values
   int left [2];
   bit pend [2];
   int sc   [2];
   int fe   [2];
   int bub  [2] = '{1, 2};
   int cmax [2] = '{65535, 15};

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [7:0] V_RST = 8'b0_000_0110;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // v = {pc_write, pc_src[2:0], ifid_write, ifid_flush, idex_flush, epc_save}
   task automatic model(input int i, output logic [7:0] v,
                        output bit tk, output int nl);
      bit haz;
      haz = memrd && (ert != 0) &&
            ((ert == rs) || (uses_rt && (ert == rt)));
      tk = 0;
      nl = left[i];
      if (rst)               v = V_RST;
      else if (busy)         v = 8'b0_000_0000;
      else if (left[i] > 0) begin
         v = 8'b0_000_0010;
         nl = left[i] - 1;
      end
      else if (undef)        v = 8'b1_101_1111;
      else if (brt)          v = 8'b1_001_1110;
      else if (pend[i]) begin
         v = 8'b1_100_1111;
         tk = 1;
      end
      else if (haz) begin
         v = 8'b0_000_0010;
         nl = bub[i] - 1;
      end
      else if (jmp == 2'b10) v = 8'b1_011_1100;
      else if (jmp == 2'b01) v = 8'b1_010_1100;
      else                   v = 8'b1_000_1000;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         left[i] = 0;
         pend[i] = 0;
         sc[i]   = 0;
         fe[i]   = 0;
      end
   endtask

   task automatic cyc(input string tag);
      logic [7:0] v;
      bit tk;
      int nl;
      @(negedge clk);
      if (rst) model_clear();
      for (int i = 0; i < 2; i++) begin
         model(i, v, tk, nl);
         chk($sformatf("%s ctrl%0d", tag, i), 32'(ctl[i]), 32'(v));
         chk($sformatf("%s stall%0d", tag, i), so[i], sc[i]);
         chk($sformatf("%s flush%0d", tag, i), fo[i], fe[i]);
         if (!rst) begin
            pend[i] = (irq && !kmode) || (pend[i] && !tk);
            left[i] = nl;
            if (!v[3] && sc[i] < cmax[i]) sc[i]++;
            if (v[2] && fe[i] < cmax[i]) fe[i]++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs = 5'd1; rt = 5'd2; ert = 5'd0; uses_rt = 1'b0;
      memrd = 1'b0; brt = 1'b0; undef = 1'b0;
      irq = 1'b0; kmode = 1'b0; busy = 1'b0; jmp = 2'b00;
   endtask

   initial begin
      idle();
      model_clear();
      cyc("reset");
      rst = 1'b0;
      cyc("idle");

      memrd = 1'b1; ert = 5'd8; rs = 5'd8;
      cyc("lduse_det");
      idle();
      cyc("lduse_b2");
      cyc("lduse_done");
      chk("stall_single", so[0], 32'd1);

      memrd = 1'b1; ert = 5'd8; rs = 5'd8;
      cyc("mw_det");
      idle(); busy = 1'b1;
      cyc("mw_freeze");
      busy = 1'b0;
      cyc("mw_resume");
      cyc("mw_done");
      chk("stall_resume", so[1], 32'd5);

      irq = 1'b1;
      cyc("irq_latch");
      irq = 1'b0; brt = 1'b1; jmp = 2'b01;
      cyc("br_over_irq");
      idle();
      cyc("irq_take");
      cyc("irq_after");

      irq = 1'b1; kmode = 1'b1;
      cyc("kirq");
      idle();
      cyc("kirq_none");

      jmp = 2'b10; memrd = 1'b1; ert = 5'd5; rs = 5'd5;
      cyc("jr_stall");
      memrd = 1'b0; ert = 5'd0;
      cyc("jr_go");
      cyc("jr_go2");
      idle();
      cyc("jr_idle");

      undef = 1'b1; brt = 1'b1; irq = 1'b1;
      cyc("undef");
      idle();
      cyc("undef_irq");

      memrd = 1'b1; ert = 5'd9; rt = 5'd9; uses_rt = 1'b1;
      cyc("rst_det");
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("async_ctrl%0d", i), 32'(ctl[i]), 32'(V_RST));
         chk($sformatf("async_stall%0d", i), so[i], 32'd0);
         chk($sformatf("async_flush%0d", i), fo[i], 32'd0);
      end
      idle();
      cyc("rst_hold");
      rst = 1'b0;
      cyc("rst_run");

      busy = 1'b1;
      for (int k = 0; k < 20; k++) cyc("sat");
      chk("sat_hold", so[1], 32'd15);
      idle();
      cyc("sat_exit");

      for (int k = 0; k < 400; k++) begin
         rs      = 5'($urandom_range(0, 3));
         rt      = 5'($urandom_range(0, 3));
         ert     = 5'($urandom_range(0, 3));
         uses_rt = 1'($urandom_range(0, 1));
         memrd   = 1'($urandom_range(0, 1));
         brt     = ($urandom_range(0, 7) == 0);
         undef   = ($urandom_range(0, 15) == 0);
         irq     = ($urandom_range(0, 5) == 0);
         kmode   = 1'($urandom_range(0, 1));
         busy    = ($urandom_range(0, 7) == 0);
         jmp     = 2'($urandom_range(0, 3));
         rst     = ($urandom_range(0, 99) == 0);
         cyc("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It owns the IF/ID register's write-enable and flush, the ID/EX bubble, PC write-enable and the 3-bit PC source select. It resolves load-use hazards, memory-wait stalls, taken branches, jumps, interrupts and exceptions under one fixed priority. It keeps an interrupt-pending latch and two performance counters.

Parameters:
LDUSE_BUBBLES, 1, stall cycles inserted per load-use hazard (1..3)
CNT_W, 16, width of performance counters (saturating)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX-stage instruction is a load
ex_rt  in  5  destination of EX-stage load
ex_branch_taken  in  1  branch in EX resolved taken
id_jump  in  2  00 none, 01 J/JAL, 10 JR/JALR
undef_instr  in  1  ID holds an undefined opcode
irq_req  in  1  external interrupt request (level)
kernel_mode  in  1  PC[31] of ID instruction; masks interrupts
mem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC register load enable
pc_src  out  3  000 PC+4, 001 branch, 010 J, 011 JR, 100 IRQ vector, 101 exception vector
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP (32'h0)
idex_flush  out  1  ID/EX loads bubble
epc_save  out  1  write ID-stage PC+4 into EPC (register $26)
stall_cycles  out  CNT_W  saturating count of cycles with ifid_write=0
flush_events  out  CNT_W  saturating count of cycles with ifid_flush=1

Behaviour:
- Reset (async): state=RUN, irq_pending=0, bubble_cnt=0, counters=0. Outputs during reset: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pc_src=000, epc_save=0.
- Control outputs are combinational from state plus inputs (zero latency). State, latch and counters update on posedge.
- irq_pending: set when irq_req & ~kernel_mode. Cleared in the cycle the IRQ is taken. Set has priority over clear in the same cycle only if irq_req is still high after the take (it is re-latched next cycle).
- States: RUN, MEMWAIT, LDUSE.
- MEMWAIT: entered from any state when mem_busy=1. In it: pc_write=0, ifid_write=0, idex_flush=0 (whole pipe frozen); all other events are ignored and remain visible on the inputs. Exits to RUN the cycle after mem_busy falls. A pending LDUSE bubble count is preserved and resumes.
- LDUSE: entered from RUN when ex_memread & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). bubble_cnt loads LDUSE_BUBBLES-1. Each LDUSE cycle: pc_write=0, ifid_write=0, idex_flush=1; bubble_cnt decrements; returns to RUN when it reaches 0. The hazard-detect cycle itself is the first bubble.
- RUN priority, highest first, exactly one action per cycle:
  1. mem_busy -> MEMWAIT behaviour.
  2. undef_instr -> pc_src=101, ifid_flush=1, idex_flush=1, epc_save=1.
  3. ex_branch_taken -> pc_src=001, ifid_flush=1, idex_flush=1. Pending IRQ and ID-stage jump/hazard are discarded this cycle (the ID instruction is squashed).
  4. irq_pending -> pc_src=100, ifid_flush=1, idex_flush=1, epc_save=1, irq_pending cleared.
  5. Load-use hazard -> LDUSE. A JR in ID with a hazard stalls first and redirects after.
  6. id_jump=10 -> pc_src=011, ifid_flush=1.
  7. id_jump=01 -> pc_src=010, ifid_flush=1.
  8. Otherwise pc_src=000, pc_write=1, ifid_write=1, flushes 0.
- Any redirect (items 2, 3, 4, 6, 7) sets pc_write=1. On a flush, ifid_write=1.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-LDUSE or mid-MEMWAIT aborts immediately to reset values.

Decomposition:
- Shared package pipe_pkg: PC_SRC_* constants (000..101), JUMP_* encodings, state encoding.
- Sub-module sat_counter (width CNT_W, inc, clear), instantiated twice.

Test Plan:
- EX lw writes $8, ID add reads rs=$8 -> one cycle pc_write=0, ifid_write=0, idex_flush=1, then RUN; stall_cycles=1.
- LDUSE_BUBBLES=2, same stimulus -> two bubble cycles; with mem_busy=1 on the second, freeze held, and the bubble resumes after mem_busy drops; stall_cycles=3.
- ex_branch_taken=1 with irq_pending=1 and id_jump=01 in the same cycle -> pc_src=001, flushes=1, epc_save=0; the IRQ is taken the next cycle with pc_src=100 and epc_save=1.
- irq_req pulse with kernel_mode=1 -> irq_pending stays 0 and no redirect occurs. The same pulse with kernel_mode=0 -> redirect to 100 within 1 cycle.
- id_jump=10 with ex_memread and ex_rt==id_rs -> a stall cycle first, then pc_src=011, ifid_flush=1, flush_events=1.
- Assert reset during LDUSE -> outputs go to reset values asynchronously and counters read 0; after release, the first cycle is RUN with pc_src=000.
